// File: rtl/bresenham_pkg.sv
// Shared types and constants for the Bresenham sequencing controller.
// The triangle path is built only when BRESENHAM_CTRL_TRIANGLE_EN is defined.
package bresenham_pkg;

  // Width of one x or y coordinate.
  localparam int unsigned COORD_W = 8;

  // Packed vertex bus {xA,yA,xB,yB,xC,yC}, MSB first.
  localparam int unsigned COORDS_W = 6 * COORD_W;

  // LSB offsets of each {x,y} vertex pair within the packed bus.
  localparam int unsigned VA_LSB = 4 * COORD_W;
  localparam int unsigned VB_LSB = 2 * COORD_W;
  localparam int unsigned VC_LSB = 0;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vertex_t;

  // Explicit encodings keep the shared states stable across both builds.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StDraw2 = 3'd1,
`ifdef BRESENHAM_CTRL_TRIANGLE_EN
    StTriAb = 3'd2,
    StTriBc = 3'd3,
    StTriCa = 3'd4,
`endif
    StGap   = 3'd5,
    StDone  = 3'd6
  } state_t;

  // A {x,y} slice of the bus maps directly onto the struct layout.
  function automatic vertex_t vertex_from_pair(input logic [2*COORD_W-1:0] pair);
    return vertex_t'(pair);
  endfunction

endpackage

// File: rtl/bresenham_seg_sel.sv
// Segment selector: maps a controller state and the A/B/C vertices to the
// segment endpoints that state issues. Purely combinational.
// The B->C and C->A edges exist only with BRESENHAM_CTRL_TRIANGLE_EN defined.
module bresenham_seg_sel
  import bresenham_pkg::*;
(
  input  state_t  state_i,
  input  vertex_t vtx_a_i,
  input  vertex_t vtx_b_i,
`ifdef BRESENHAM_CTRL_TRIANGLE_EN
  input  vertex_t vtx_c_i,
`endif
  output logic    draw_o,
  output vertex_t p0_o,
  output vertex_t p1_o
);

  // Decode draw states into their start/end vertices; non-draw states flag draw_o low.
  always_comb begin
    draw_o = 1'b1;
    p0_o   = vtx_a_i;
    p1_o   = vtx_b_i;
    unique case (state_i)
      StDraw2: begin
        p0_o = vtx_a_i;
        p1_o = vtx_b_i;
      end
`ifdef BRESENHAM_CTRL_TRIANGLE_EN
      StTriAb: begin
        p0_o = vtx_a_i;
        p1_o = vtx_b_i;
      end
      StTriBc: begin
        p0_o = vtx_b_i;
        p1_o = vtx_c_i;
      end
      StTriCa: begin
        p0_o = vtx_c_i;
        p1_o = vtx_a_i;
      end
`endif
      default: draw_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/bresenham_ctrl.sv
// Bresenham sequencing controller: latches a vertex list on bla_en, issues
// one line segment at a time to the line drawer, waits for draw_done between
// segments and pulses bla_done when the primitive is finished.
// Triangle support is compiled in only when BRESENHAM_CTRL_TRIANGLE_EN is
// defined; otherwise every request draws the single A->B segment.
module bresenham_ctrl
  import bresenham_pkg::*;
(
  input  logic                clk,
  input  logic                n_rst,
  input  logic                bla_en,
  input  logic                vertice_num,
  input  logic [COORDS_W-1:0] coordinates,
  input  logic                draw_done,
  output logic [COORD_W-1:0]  x0,
  output logic [COORD_W-1:0]  y0,
  output logic [COORD_W-1:0]  x1,
  output logic [COORD_W-1:0]  y1,
  output logic                draw_en,
  output logic                bla_done
);

  state_t state_q, state_d;
  // State entered when the current GAP cycle ends.
  state_t ret_q, ret_d;

  vertex_t vtx_a_q, vtx_a_d;
  vertex_t vtx_b_q, vtx_b_d;
`ifdef BRESENHAM_CTRL_TRIANGLE_EN
  vertex_t vtx_c_q, vtx_c_d;
`else
  // Inputs that only the triangle path consumes.
  logic unused_tri_inputs;
  assign unused_tri_inputs = vertice_num ^ (^coordinates[VC_LSB +: 2*COORD_W]);
`endif

  logic [COORD_W-1:0] x0_q, x0_d;
  logic [COORD_W-1:0] y0_q, y0_d;
  logic [COORD_W-1:0] x1_q, x1_d;
  logic [COORD_W-1:0] y1_q, y1_d;
  logic               draw_en_q, draw_en_d;
  logic               bla_done_q, bla_done_d;

  logic    start;
  logic    seg_draw;
  vertex_t seg_p0;
  vertex_t seg_p1;

  assign start = (state_q == StIdle) && bla_en;

  // Next-state: advance through segments, detouring via GAP after each draw_done.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    unique case (state_q)
      StIdle: begin
        if (bla_en) begin
`ifdef BRESENHAM_CTRL_TRIANGLE_EN
          state_d = vertice_num ? StTriAb : StDraw2;
`else
          state_d = StDraw2;
`endif
        end
      end
      StDraw2: begin
        if (draw_done) begin
          state_d = StGap;
          ret_d   = StDone;
        end
      end
`ifdef BRESENHAM_CTRL_TRIANGLE_EN
      StTriAb: begin
        if (draw_done) begin
          state_d = StGap;
          ret_d   = StTriBc;
        end
      end
      StTriBc: begin
        if (draw_done) begin
          state_d = StGap;
          ret_d   = StTriCa;
        end
      end
      StTriCa: begin
        if (draw_done) begin
          state_d = StGap;
          ret_d   = StDone;
        end
      end
`endif
      StGap:   state_d = ret_q;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Vertex capture: load from the bus only on an accepted request.
  always_comb begin
    vtx_a_d = vtx_a_q;
    vtx_b_d = vtx_b_q;
`ifdef BRESENHAM_CTRL_TRIANGLE_EN
    vtx_c_d = vtx_c_q;
`endif
    if (start) begin
      vtx_a_d = vertex_from_pair(coordinates[VA_LSB +: 2*COORD_W]);
      vtx_b_d = vertex_from_pair(coordinates[VB_LSB +: 2*COORD_W]);
`ifdef BRESENHAM_CTRL_TRIANGLE_EN
      vtx_c_d = vertex_from_pair(coordinates[VC_LSB +: 2*COORD_W]);
`endif
    end
  end

  // Segment for the state being entered; the vertices fed in are the
  // post-latch values so the first segment is valid right after bla_en.
  bresenham_seg_sel u_seg_sel (
    .state_i (state_d),
    .vtx_a_i (vtx_a_d),
    .vtx_b_i (vtx_b_d),
`ifdef BRESENHAM_CTRL_TRIANGLE_EN
    .vtx_c_i (vtx_c_d),
`endif
    .draw_o  (seg_draw),
    .p0_o    (seg_p0),
    .p1_o    (seg_p1)
  );

  // Output next-state: endpoints load on draw states and hold otherwise.
  always_comb begin
    x0_d       = x0_q;
    y0_d       = y0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    draw_en_d  = seg_draw;
    bla_done_d = (state_d == StDone);
    if (seg_draw) begin
      x0_d = seg_p0.x;
      y0_d = seg_p0.y;
      x1_d = seg_p1.x;
      y1_d = seg_p1.y;
    end
  end

  // State, vertex and output registers; reset aborts any primitive at once.
  always_ff @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      state_q    <= StIdle;
      ret_q      <= StDone;
      vtx_a_q    <= '0;
      vtx_b_q    <= '0;
`ifdef BRESENHAM_CTRL_TRIANGLE_EN
      vtx_c_q    <= '0;
`endif
      x0_q       <= '0;
      y0_q       <= '0;
      x1_q       <= '0;
      y1_q       <= '0;
      draw_en_q  <= 1'b0;
      bla_done_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      vtx_a_q    <= vtx_a_d;
      vtx_b_q    <= vtx_b_d;
`ifdef BRESENHAM_CTRL_TRIANGLE_EN
      vtx_c_q    <= vtx_c_d;
`endif
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      x1_q       <= x1_d;
      y1_q       <= y1_d;
      draw_en_q  <= draw_en_d;
      bla_done_q <= bla_done_d;
    end
  end

  assign x0       = x0_q;
  assign y0       = y0_q;
  assign x1       = x1_q;
  assign y1       = y1_q;
  assign draw_en  = draw_en_q;
  assign bla_done = bla_done_q;

endmodule

// File: tb/tb_bresenham_ctrl.sv
// Self-checking bench for bresenham_ctrl. A segment-list reference model is
// compared against the DUT every cycle; directed literal checks pin the model.
// Expectations follow BRESENHAM_CTRL_TRIANGLE_EN when it is defined.
module tb_bresenham_ctrl;
  import bresenham_pkg::*;

`ifdef BRESENHAM_CTRL_TRIANGLE_EN
  localparam bit TriEn = 1'b1;
`else
  localparam bit TriEn = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                n_rst = 1'b1;
  logic                bla_en = 1'b0;
  logic                vertice_num = 1'b0;
  logic                draw_done = 1'b0;
  logic [COORDS_W-1:0] coordinates = '0;
  logic [COORD_W-1:0]  x0, y0, x1, y1;
  logic                draw_en, bla_done;

  always #5 clk = ~clk;

  bresenham_ctrl dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .bla_en      (bla_en),
    .vertice_num (vertice_num),
    .coordinates (coordinates),
    .draw_done   (draw_done),
    .x0          (x0),
    .y0          (y0),
    .x1          (x1),
    .y1          (y1),
    .draw_en     (draw_en),
    .bla_done    (bla_done)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
  endtask

  // Reference model: a list of segments, each issued, held until draw_done,
  // followed by one idle cycle; after the last idle cycle a one-cycle done.
  logic       m_draw, m_gap, m_done;
  int         m_idx, m_nseg;
  logic [7:0] m_vx [3];
  logic [7:0] m_vy [3];
  logic [7:0] e_x0, e_y0, e_x1, e_y1;

  always @(posedge clk or posedge n_rst) begin
    if (n_rst) begin
      m_draw <= 1'b0; m_gap <= 1'b0; m_done <= 1'b0;
      m_idx <= 0; m_nseg <= 0;
      e_x0 <= '0; e_y0 <= '0; e_x1 <= '0; e_y1 <= '0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_gap) begin
      m_gap <= 1'b0;
      if (m_idx < m_nseg) begin
        e_x0 <= m_vx[m_idx];           e_y0 <= m_vy[m_idx];
        e_x1 <= m_vx[(m_idx + 1) % 3]; e_y1 <= m_vy[(m_idx + 1) % 3];
        m_draw <= 1'b1;
      end else begin
        m_done <= 1'b1;
      end
    end else if (m_draw) begin
      if (draw_done) begin
        m_draw <= 1'b0;
        m_gap  <= 1'b1;
        m_idx  <= m_idx + 1;
      end
    end else if (bla_en) begin
      m_vx[0] <= coordinates[47:40]; m_vy[0] <= coordinates[39:32];
      m_vx[1] <= coordinates[31:24]; m_vy[1] <= coordinates[23:16];
      m_vx[2] <= coordinates[15:8];  m_vy[2] <= coordinates[7:0];
      m_nseg  <= (TriEn && vertice_num) ? 3 : 1;
      m_idx   <= 0;
      e_x0 <= coordinates[47:40]; e_y0 <= coordinates[39:32];
      e_x1 <= coordinates[31:24]; e_y1 <= coordinates[23:16];
      m_draw <= 1'b1;
    end
  end

  logic [31:0] seg_log [$];
  int          done_cnt = 0;
  logic        prev_en = 1'b0;

  task automatic wait_draw_en(input int max_cyc);
    int n = 0;
    while (!draw_en && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("draw_en_wait", draw_en, 1);
  endtask

  initial begin
    int nseg;
    int busy_seg;
    int c;
    nseg     = TriEn ? 3 : 1;
    busy_seg = TriEn ? 1 : 0;

    fork
      forever begin
        @(negedge clk);
        if (!n_rst) begin
          check("cycle_model", {30'd0, draw_en, bla_done, x0, y0, x1, y1},
                {30'd0, m_draw, m_done, e_x0, e_y0, e_x1, e_y1});
          if (draw_en && !prev_en) seg_log.push_back({x0, y0, x1, y1});
          if (bla_done) done_cnt++;
          prev_en = draw_en;
        end else begin
          prev_en = 1'b0;
        end
      end
    join_none

    repeat (2) @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    check("reset_outputs", {draw_en, bla_done, x0, y0, x1, y1}, 0);

    // Idle hold.
    repeat (5) begin
      @(negedge clk);
      check("idle_hold", {draw_en, bla_done}, 0);
    end

    // Line with a long draw.
    coordinates = 48'h0A_14_1E_28_0000;
    vertice_num = 1'b0;
    bla_en = 1'b1;
    @(negedge clk);
    bla_en = 1'b0;
    check("line_first_seg", {draw_en, x0, y0, x1, y1}, {1'b1, 32'h0A141E28});
    repeat (10) @(negedge clk);
    check("line_hold", draw_en, 1);
    draw_done = 1'b1;
    @(negedge clk);
    check("line_gap", {draw_en, bla_done, x0, y0, x1, y1}, {2'b00, 32'h0A141E28});
    // draw_done still high through GAP: must be ignored.
    @(negedge clk);
    draw_done = 1'b0;
    check("line_done", {draw_en, bla_done}, 2'b01);
    @(negedge clk);
    check("line_done_once", bla_done, 0);

    // Spurious draw_done in IDLE.
    draw_done = 1'b1;
    @(negedge clk);
    draw_done = 1'b0;
    @(negedge clk);
    check("idle_spurious_done", {draw_en, bla_done}, 0);

    // Triangle, drawer answers 4 cycles after each draw_en rise.
    seg_log.delete();
    done_cnt = 0;
    coordinates = 48'h01_02_03_04_05_06;
    vertice_num = 1'b1;
    bla_en = 1'b1;
    @(negedge clk);
    bla_en = 1'b0;
    for (int s = 0; s < nseg; s++) begin
      wait_draw_en(20);
      if (s == busy_seg) begin
        bla_en = 1'b1;
        coordinates = 48'hFF_EE_DD_CC_BB_AA;
        vertice_num = 1'b0;
      end
      repeat (3) @(negedge clk);
      bla_en = 1'b0;
      draw_done = 1'b1;
      @(negedge clk);
      draw_done = 1'b0;
    end
    repeat (6) @(negedge clk);
    check("tri_done_count", done_cnt, 1);
    check("tri_seg_count", seg_log.size(), nseg);
`ifdef BRESENHAM_CTRL_TRIANGLE_EN
    check("tri_seg_ab", seg_log[0], 32'h01020304);
    check("tri_seg_bc", seg_log[1], 32'h03040506);
    check("tri_seg_ca", seg_log[2], 32'h05060102);
`else
    check("line_only_seg", seg_log[0], 32'h01020304);
`endif

    // draw_done held high: minimum-length line, degenerate segment.
    draw_done = 1'b1;
    coordinates = 48'h05_05_05_05_0000;
    vertice_num = 1'b0;
    bla_en = 1'b1;
    @(negedge clk);
    bla_en = 1'b0;
    check("degen_issued", {draw_en, x0, y0, x1, y1}, {1'b1, 32'h05050505});
    c = 1;
    while (!bla_done && c < 10) begin
      @(negedge clk);
      c++;
    end
    check("min_line_cycles", c, 3);

    // Request during DONE must wait for the first IDLE cycle.
    coordinates = 48'h11_22_33_44_5566;
    bla_en = 1'b1;
    @(negedge clk);
    check("no_early_accept", draw_en, 0);
    @(negedge clk);
    bla_en = 1'b0;
    check("accept_after_idle", {draw_en, x0, y0, x1, y1}, {1'b1, 32'h11223344});
    repeat (3) @(negedge clk);
    draw_done = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of DRAW2.
    coordinates = 48'h0A_14_1E_28_0000;
    bla_en = 1'b1;
    @(negedge clk);
    bla_en = 1'b0;
    @(negedge clk);
    check("pre_reset_draw", draw_en, 1);
    #2 n_rst = 1'b1;
    #1 check("reset_mid_draw", {draw_en, bla_done, x0, y0, x1, y1}, 0);
    @(negedge clk);
    n_rst = 1'b0;
    @(negedge clk);
    check("post_reset_idle", {draw_en, bla_done, x0, y0, x1, y1}, 0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_chk);
    $fatal(1);
  end

endmodule
